// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// interrupt cause codes, mstatus bit positions, FSM state encoding and the
// fixed interrupt priority selector.
package trap_controller_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MITRIG   = 12'h7C1;

   localparam logic [4:0] CAUSE_MSI = 5'd3;
   localparam logic [4:0] CAUSE_MTI = 5'd7;
   localparam logic [4:0] CAUSE_MEI = 5'd11;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_HANDLER = 1'b1
   } trap_state_t;

   // MEI > MSI > MTI > user lines, lowest user index first. Later
   // assignments override earlier ones, so the scan runs lowest priority first.
   function automatic logic [4:0] irq_select(input logic [31:0] pend);
      logic [4:0] code;
      code = 5'd0;
      for (int i = 31; i >= 16; i--) begin
         if (pend[i]) code = 5'(i);
      end
      if (pend[CAUSE_MTI]) code = CAUSE_MTI;
      if (pend[CAUSE_MSI]) code = CAUSE_MSI;
      if (pend[CAUSE_MEI]) code = CAUSE_MEI;
      return code;
   endfunction

endpackage

// File: rtl/trap_controller_irq_sync.sv
// Per-line interrupt conditioner: SYNC_STAGES-deep synchroniser followed by
// an optional sticky rising-edge latch.
// Ports:
//   clk        core clock
//   rst        synchronous active-low reset
//   raw        asynchronous interrupt level
//   edge_mode  1 = report the sticky edge latch, 0 = report the synced level
//   clear      software clear of the edge latch (a same-cycle edge wins)
//   line       conditioned interrupt line
module trap_controller_irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic edge_mode,
   input  logic clear,
   output logic line
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   latch_q;
   logic                   rise;

   assign rise = edge_mode & sync_q[SYNC_STAGES-1] & ~prev_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         latch_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
         prev_q  <= sync_q[SYNC_STAGES-1];
         latch_q <= (latch_q & ~clear) | rise;
      end
   end

   assign line = edge_mode ? latch_q : sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap controller: synchronises and prioritises the machine and
// user interrupts, holds the machine trap CSRs and runs the
// trapRequest/trapAccept handshake with direct or vectored mtvec.
// Optional feature macro: TRAP_CONTROLLER_EDGE_TRIGGER_EN adds CSR 0x7C1
// (mitrig) selecting edge-triggered user lines, cleared by writing 0 to mip.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   csrWriteEnable/Address/Data   CSR write port
//   csrReadEnable/Address         CSR read port
//   csrReadData, csrRequestOutput read data (0 when not addressed), hit flag
//   programCounter                PC of the instruction at the trap boundary
//   exceptionValid/Cause/Value    synchronous exception from the pipeline
//   machine*Interrupt, userInterrupts  asynchronous interrupt levels
//   trapRequest, trapAccept       trap handshake
//   trapReturn                    mret retired
//   trapVector, trapReturnVector  handler address, mepc
//   inTrapHandler                 FSM in HANDLER
//
// state      | meaning
// ST_RUN     | normal execution, interrupts taken when MIE=1
// ST_HANDLER | inside a trap handler, only exceptions trap
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int          USER_IRQ_COUNT = 16,
   parameter int          SYNC_STAGES    = 2,
   parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      csrWriteEnable,
   input  logic                      csrReadEnable,
   input  logic [11:0]               csrWriteAddress,
   input  logic [11:0]               csrReadAddress,
   input  logic [31:0]               csrWriteData,
   output logic [31:0]               csrReadData,
   output logic                      csrRequestOutput,
   input  logic [31:0]               programCounter,
   input  logic                      exceptionValid,
   input  logic [3:0]                exceptionCause,
   input  logic [31:0]               exceptionValue,
   input  logic                      machineSoftwareInterrupt,
   input  logic                      machineTimerInterrupt,
   input  logic                      machineExternalInterrupt,
   input  logic [USER_IRQ_COUNT-1:0] userInterrupts,
   output logic                      trapRequest,
   input  logic                      trapAccept,
   input  logic                      trapReturn,
   output logic [31:0]               trapVector,
   output logic [31:0]               trapReturnVector,
   output logic                      inTrapHandler
);

   localparam logic [31:0] USER_MASK = 32'(((64'd1 << USER_IRQ_COUNT) - 64'd1) << 16);
   localparam logic [31:0] MIE_MASK  = USER_MASK | 32'h0000_0888;

   trap_state_t state_q, state_d;

   logic        mstatus_mie_q, mstatus_mpie_q;
   logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

   logic [2:0]                sys_raw, sys_sync;
   logic [USER_IRQ_COUNT-1:0] user_sync, edge_mode, mip_clear;
   logic [31:0]               irq_vec, pending, sel_cause, base, rd_data;
   logic [4:0]                irq_code;
   logic                      irq_take, irq_sel, accept, rd_hit;

   assign sys_raw = {machineExternalInterrupt, machineTimerInterrupt, machineSoftwareInterrupt};

   for (genvar g = 0; g < 3; g++) begin : g_sys
      trap_controller_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk(clk), .rst(rst), .raw(sys_raw[g]), .edge_mode(1'b0),
         .clear(1'b0), .line(sys_sync[g]));
   end

   for (genvar g = 0; g < USER_IRQ_COUNT; g++) begin : g_user
      trap_controller_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk(clk), .rst(rst), .raw(userInterrupts[g]), .edge_mode(edge_mode[g]),
         .clear(mip_clear[g]), .line(user_sync[g]));
   end

`ifdef TRAP_CONTROLLER_EDGE_TRIGGER_EN
   logic [USER_IRQ_COUNT-1:0] mitrig_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mitrig_q <= '0;
      end else if (csrWriteEnable && csrWriteAddress == CSR_MITRIG) begin
         mitrig_q <= csrWriteData[USER_IRQ_COUNT-1:0];
      end
   end

   assign edge_mode = mitrig_q;
   assign mip_clear = (csrWriteEnable && csrWriteAddress == CSR_MIP) ?
                      ~csrWriteData[16 +: USER_IRQ_COUNT] : '0;
`else
   assign edge_mode = '0;
   assign mip_clear = '0;
`endif

   always_comb begin
      irq_vec                         = '0;
      irq_vec[CAUSE_MSI]              = sys_sync[0];
      irq_vec[CAUSE_MTI]              = sys_sync[1];
      irq_vec[CAUSE_MEI]              = sys_sync[2];
      irq_vec[16 +: USER_IRQ_COUNT]   = user_sync;
   end

   assign pending  = irq_vec & mie_q;
   assign irq_code = irq_select(pending);
   assign irq_take = (state_q == ST_RUN) & mstatus_mie_q & (|pending);
   assign irq_sel  = ~exceptionValid & irq_take;

   assign trapRequest = exceptionValid | irq_take;
   assign accept      = trapRequest & trapAccept;

   assign sel_cause = exceptionValid ? {1'b0, 27'b0, exceptionCause} : {1'b1, 26'b0, irq_code};

   assign base       = {mtvec_q[31:2], 2'b00};
   assign trapVector = (mtvec_q[1:0] == 2'b01 && irq_sel) ? base + {25'b0, irq_code, 2'b00} : base;

   assign trapReturnVector = mepc_q;
   assign inTrapHandler    = (state_q == ST_HANDLER);

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   // Accept beats a simultaneous return.
   always_comb begin
      state_d = state_q;
      if (accept)          state_d = ST_HANDLER;
      else if (trapReturn) state_d = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= MTVEC_RESET;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
      end else begin
         if (csrWriteEnable) begin
            case (csrWriteAddress)
               CSR_MIE:      mie_q      <= csrWriteData & MIE_MASK;
               // Reserved modes 1x collapse to direct.
               CSR_MTVEC:    mtvec_q    <= {csrWriteData[31:2], 1'b0, csrWriteData[0] & ~csrWriteData[1]};
               CSR_MSCRATCH: mscratch_q <= csrWriteData;
               default: ;
            endcase
         end
         // Trap commit/return own mstatus/mepc/mcause/mtval in their cycle.
         if (accept) begin
            mepc_q         <= programCounter & 32'hFFFF_FFFE;
            mcause_q       <= sel_cause;
            mtval_q        <= exceptionValid ? exceptionValue : 32'h0;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
         end else if (trapReturn) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end else if (csrWriteEnable) begin
            case (csrWriteAddress)
               CSR_MSTATUS: begin
                  mstatus_mie_q  <= csrWriteData[MSTATUS_MIE_BIT];
                  mstatus_mpie_q <= csrWriteData[MSTATUS_MPIE_BIT];
               end
               CSR_MEPC:   mepc_q   <= csrWriteData & 32'hFFFF_FFFE;
               CSR_MCAUSE: mcause_q <= csrWriteData;
               CSR_MTVAL:  mtval_q  <= csrWriteData;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_hit  = 1'b1;
      rd_data = '0;
      case (csrReadAddress)
         CSR_MSTATUS: begin
            rd_data[MSTATUS_MIE_BIT]  = mstatus_mie_q;
            rd_data[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
         end
         CSR_MIE:      rd_data = mie_q;
         CSR_MTVEC:    rd_data = mtvec_q;
         CSR_MSCRATCH: rd_data = mscratch_q;
         CSR_MEPC:     rd_data = mepc_q;
         CSR_MCAUSE:   rd_data = mcause_q;
         CSR_MTVAL:    rd_data = mtval_q;
         CSR_MIP:      rd_data = irq_vec;
`ifdef TRAP_CONTROLLER_EDGE_TRIGGER_EN
         CSR_MITRIG:   rd_data[USER_IRQ_COUNT-1:0] = mitrig_q;
`endif
         default:      rd_hit = 1'b0;
      endcase
   end

   assign csrRequestOutput = csrReadEnable & rd_hit;
   assign csrReadData      = csrRequestOutput ? rd_data : 32'h0;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: expected values are queued when a
// stimulus is applied and compared in order as the DUT responds.
module tb_trap_controller;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MITRIG   = 12'h7C1;

   logic        clk = 1'b0;
   logic        rst;
   logic        csrWriteEnable, csrReadEnable;
   logic [11:0] csrWriteAddress, csrReadAddress;
   logic [31:0] csrWriteData, csrReadData;
   logic        csrRequestOutput;
   logic [31:0] programCounter;
   logic        exceptionValid;
   logic [3:0]  exceptionCause;
   logic [31:0] exceptionValue;
   logic        machineSoftwareInterrupt, machineTimerInterrupt, machineExternalInterrupt;
   logic [15:0] userInterrupts;
   logic        trapRequest, trapAccept, trapReturn;
   logic [31:0] trapVector, trapReturnVector;
   logic        inTrapHandler;

   int errors = 0;
   int checks = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   trap_controller dut (
      .clk(clk), .rst(rst),
      .csrWriteEnable(csrWriteEnable), .csrReadEnable(csrReadEnable),
      .csrWriteAddress(csrWriteAddress), .csrReadAddress(csrReadAddress),
      .csrWriteData(csrWriteData), .csrReadData(csrReadData),
      .csrRequestOutput(csrRequestOutput), .programCounter(programCounter),
      .exceptionValid(exceptionValid), .exceptionCause(exceptionCause),
      .exceptionValue(exceptionValue),
      .machineSoftwareInterrupt(machineSoftwareInterrupt),
      .machineTimerInterrupt(machineTimerInterrupt),
      .machineExternalInterrupt(machineExternalInterrupt),
      .userInterrupts(userInterrupts), .trapRequest(trapRequest),
      .trapAccept(trapAccept), .trapReturn(trapReturn),
      .trapVector(trapVector), .trapReturnVector(trapReturnVector),
      .inTrapHandler(inTrapHandler));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      tag_q.push_back(tag);
      exp_q.push_back(val);
   endtask

   task automatic sb_check(input logic [31:0] got);
      string       t;
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         check(t, got, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      csrWriteEnable  = 1'b1;
      csrWriteAddress = a;
      csrWriteData    = d;
      tick();
      csrWriteEnable  = 1'b0;
   endtask

   task automatic sb_rd(input logic [11:0] a);
      csrReadEnable  = 1'b1;
      csrReadAddress = a;
      #1;
      sb_check(csrReadData);
      csrReadEnable  = 1'b0;
   endtask

   task automatic sb_req(input logic [11:0] a);
      csrReadEnable  = 1'b1;
      csrReadAddress = a;
      #1;
      sb_check({31'b0, csrRequestOutput});
      csrReadEnable  = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      csrWriteEnable = 0; csrReadEnable = 0; csrWriteAddress = '0; csrReadAddress = '0;
      csrWriteData = '0; programCounter = '0; exceptionValid = 0; exceptionCause = '0;
      exceptionValue = '0; machineSoftwareInterrupt = 0; machineTimerInterrupt = 0;
      machineExternalInterrupt = 0; userInterrupts = '0; trapAccept = 0; trapReturn = 0;
      tick(); tick();
      rst = 1'b1;
      tick();

      // Reset state
      sb_push("rst_req", 0);         sb_check({31'b0, trapRequest});
      sb_push("rst_handler", 0);     sb_check({31'b0, inTrapHandler});
      sb_push("rst_rdata_idle", 0);  sb_check(csrReadData);
      sb_push("rst_mtvec", 0);       sb_rd(A_MTVEC);
      sb_push("rst_mstatus", 0);     sb_rd(A_MSTATUS);

      // CSR boundaries
      csr_wr(A_MTVEC, 32'h102);      sb_push("mtvec_mode1x", 32'h100);    sb_rd(A_MTVEC);
      csr_wr(A_MEPC, 32'h333);       sb_push("mepc_bit0", 32'h332);       sb_rd(A_MEPC);
      csr_wr(A_MSCRATCH, 32'hCAFEF00D); sb_push("mscratch", 32'hCAFEF00D); sb_rd(A_MSCRATCH);
      sb_push("req_unmapped", 0);    sb_req(12'h123);
      sb_push("req_mstatus", 1);     sb_req(A_MSTATUS);
`ifdef TRAP_CONTROLLER_EDGE_TRIGGER_EN
      sb_push("req_mitrig", 1);      sb_req(A_MITRIG);
`else
      sb_push("req_mitrig", 0);      sb_req(A_MITRIG);
`endif

      // 1: direct mode, MTI
      csr_wr(A_MTVEC, 32'h100);
      csr_wr(A_MSTATUS, 32'h8);
      csr_wr(A_MIE, 32'h80);
      machineTimerInterrupt = 1'b1;
      tick(); sb_push("t1_req_1clk", 0); sb_check({31'b0, trapRequest});
      tick(); sb_push("t1_req_2clk", 1); sb_check({31'b0, trapRequest});
      sb_push("t1_vector", 32'h100); sb_check(trapVector);
      sb_push("t1_mip", 32'h80);     sb_rd(A_MIP);
      programCounter = 32'h40; trapAccept = 1'b1;
      tick();
      trapAccept = 1'b0;
      sb_push("t1_mepc", 32'h40);
      sb_push("t1_mcause", 32'h8000_0007);
      sb_push("t1_mstatus", 32'h80);
      sb_push("t1_handler", 1);
      sb_rd(A_MEPC); sb_rd(A_MCAUSE); sb_rd(A_MSTATUS); sb_check({31'b0, inTrapHandler});
      machineTimerInterrupt = 1'b0;
      tick(); tick(); tick();
      trapReturn = 1'b1; tick(); trapReturn = 1'b0;
      sb_push("t1_ret_mstatus", 32'h88); sb_rd(A_MSTATUS);
      sb_push("t1_ret_handler", 0);      sb_check({31'b0, inTrapHandler});

      // 2: vectored, priority MTI over user 3
      csr_wr(A_MTVEC, 32'h101);          sb_push("t2_mtvec", 32'h101);     sb_rd(A_MTVEC);
      csr_wr(A_MIE, 32'hFFFF_FFFF);      sb_push("t2_mie_mask", 32'hFFFF_0888); sb_rd(A_MIE);
      userInterrupts = 16'h0008; machineTimerInterrupt = 1'b1;
      tick(); tick();
      sb_push("t2_req", 1);              sb_check({31'b0, trapRequest});
      sb_push("t2_vec_mti", 32'h11C);    sb_check(trapVector);
      machineTimerInterrupt = 1'b0;
      tick(); tick();
      sb_push("t2_vec_user3", 32'h14C);  sb_check(trapVector);
      programCounter = 32'h80; trapAccept = 1'b1;
      tick();
      trapAccept = 1'b0;
      sb_push("t2_mcause", 32'h8000_0013); sb_rd(A_MCAUSE);
      sb_push("t2_retvec", 32'h80);        sb_check(trapReturnVector);
      sb_push("t2_mstatus", 32'h80);       sb_rd(A_MSTATUS);

      // 3: exception inside handler
      sb_push("t3_req_masked", 0);       sb_check({31'b0, trapRequest});
      exceptionValid = 1'b1; exceptionCause = 4'd2; exceptionValue = 32'hDEAD;
      #1;
      sb_push("t3_req_exc", 1);          sb_check({31'b0, trapRequest});
      sb_push("t3_vec_exc", 32'h100);    sb_check(trapVector);
      programCounter = 32'h44; trapAccept = 1'b1;
      tick();
      trapAccept = 1'b0; exceptionValid = 1'b0; userInterrupts = '0;
      sb_push("t3_mtval", 32'hDEAD);     sb_rd(A_MTVAL);
      sb_push("t3_mcause", 32'h2);       sb_rd(A_MCAUSE);
      sb_push("t3_mepc", 32'h44);        sb_rd(A_MEPC);
      sb_push("t3_mstatus", 32'h0);      sb_rd(A_MSTATUS);

      // 4: accept + return + mepc write in one cycle
      exceptionValid = 1'b1; exceptionCause = 4'd5; exceptionValue = 32'h1234;
      programCounter = 32'h200; trapAccept = 1'b1; trapReturn = 1'b1;
      csrWriteEnable = 1'b1; csrWriteAddress = A_MEPC; csrWriteData = 32'hABCD0;
      tick();
      exceptionValid = 1'b0; trapAccept = 1'b0; trapReturn = 1'b0; csrWriteEnable = 1'b0;
      sb_push("t4_mepc", 32'h200);       sb_rd(A_MEPC);
      sb_push("t4_mcause", 32'h5);       sb_rd(A_MCAUSE);
      sb_push("t4_mtval", 32'h1234);     sb_rd(A_MTVAL);
      sb_push("t4_handler", 1);          sb_check({31'b0, inTrapHandler});
      csr_wr(A_MSTATUS, 32'h80);
      trapReturn = 1'b1; tick(); trapReturn = 1'b0;
      sb_push("t4_ret_mstatus", 32'h88); sb_rd(A_MSTATUS);
      sb_push("t4_ret_handler", 0);      sb_check({31'b0, inTrapHandler});

`ifdef TRAP_CONTROLLER_EDGE_TRIGGER_EN
      // 5: edge-triggered user line 0
      csr_wr(A_MITRIG, 32'h1);           sb_push("t5_mitrig", 32'h1); sb_rd(A_MITRIG);
      csr_wr(A_MIE, 32'h1_0000);
      userInterrupts = 16'h1; tick(); userInterrupts = '0; tick(); tick();
      sb_push("t5_req", 1);              sb_check({31'b0, trapRequest});
      tick(); tick();
      sb_push("t5_req_held", 1);         sb_check({31'b0, trapRequest});
      programCounter = 32'h300; trapAccept = 1'b1; tick(); trapAccept = 1'b0;
      sb_push("t5_mcause", 32'h8000_0010); sb_rd(A_MCAUSE);
      sb_push("t5_mip_after_acc", 32'h1_0000); sb_rd(A_MIP);
      trapReturn = 1'b1; tick(); trapReturn = 1'b0;
      sb_push("t5_req_again", 1);        sb_check({31'b0, trapRequest});
      csr_wr(A_MIP, 32'h0);
      sb_push("t5_mip_clr", 0);          sb_rd(A_MIP);
      sb_push("t5_req_clr", 0);          sb_check({31'b0, trapRequest});
      userInterrupts = 16'h1; tick(); userInterrupts = '0; tick(); tick();
      userInterrupts = 16'h1; tick(); userInterrupts = '0; tick();
      csr_wr(A_MIP, 32'h0);
      sb_push("t5_edge_wins", 32'h1_0000); sb_rd(A_MIP);
      csr_wr(A_MIE, 32'h0);
`endif

      // 6: reset during handshake
      exceptionValid = 1'b1; exceptionCause = 4'd4; exceptionValue = 32'h77;
      programCounter = 32'h500;
      #1;
      sb_push("t6_req", 1);              sb_check({31'b0, trapRequest});
      trapAccept = 1'b1; rst = 1'b0;
      tick();
      trapAccept = 1'b0; exceptionValid = 1'b0;
      sb_push("t6_mepc", 0);             sb_rd(A_MEPC);
      sb_push("t6_mcause", 0);           sb_rd(A_MCAUSE);
      sb_push("t6_mtval", 0);            sb_rd(A_MTVAL);
      sb_push("t6_mstatus", 0);          sb_rd(A_MSTATUS);
      sb_push("t6_mtvec", 0);            sb_rd(A_MTVEC);
      sb_push("t6_mie", 0);              sb_rd(A_MIE);
      sb_push("t6_handler", 0);          sb_check({31'b0, inTrapHandler});
      rst = 1'b1;
      tick();
      sb_push("t6_mscratch", 0);         sb_rd(A_MSCRATCH);
      sb_push("t6_req_after", 0);        sb_check({31'b0, trapRequest});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
